pll_supervisor: RTL and testbench
=================================

# pll_supervisor

Sequencing controller for an iCE40 SB_PLL40_CORE instance, running on the PLL reference clock. It drives the PLL's active-low RESETB and synchronises the asynchronous LOCK output. It waits for lock to stay continuously stable before releasing `ready` to the fast-clock domain's reset logic. It also retries lock acquisition a bounded number of times, then latches a failure flag.

## Interface
- `PLL_RESET_CYCLES`, default 16: cycles RESETB is held low per (re)start attempt; ≥2.
- `LOCK_STABLE_CYCLES`, default 4096: consecutive synchronised-lock-high cycles required before `ready`; ≥1.
- `LOCK_TIMEOUT_CYCLES`, default 65536: budget per attempt, counted from WAIT_LOCK entry until RUN; ≥ LOCK_STABLE_CYCLES+4.
- `MAX_RETRIES`, default 3: failed attempts tolerated before FAIL; 1..15.
- `clock` in 1: PLL reference clock, the only clock.
- `reset` in 1: synchronous, active-high.
- `restart` in 1: synchronous pulse; restarts the sequence from any state.
- `locked_in` in 1: PLL LOCK, asynchronous to `clock`.
- `pll_resetb` out 1: to PLL RESETB, active-low, registered.
- `ready` out 1: high only in RUN, registered.
- `fail` out 1: high only in FAIL, registered.
- `retries` out 4: failed attempts since last RUN/restart/reset.
- `lock_lost_count` out 8: lock losses seen in RUN; saturates at 255.

## Operation
- `locked_in` passes through a 2-flop synchroniser → `lock_sync`. Only `lock_sync` is used.
- Counters: `phase_cnt`, used for the reset hold and for stability; `timeout_cnt`; width `$clog2` of the largest parameter plus 1.
- PLL_RESET: `pll_resetb`=0. `phase_cnt` increments. At `phase_cnt`==PLL_RESET_CYCLES-1 → WAIT_LOCK, and `timeout_cnt` is cleared.
- WAIT_LOCK: `pll_resetb`=1. `timeout_cnt` increments.
  - If `lock_sync` → STABLE, with `phase_cnt` cleared.
  - Else if `timeout_cnt`==LOCK_TIMEOUT_CYCLES-1 → timeout.
- STABLE: `timeout_cnt` keeps incrementing and is not cleared.
  - If `lock_sync`=0 → WAIT_LOCK, with `timeout_cnt` retained, so a flapping lock cannot evade the timeout.
  - Else if `phase_cnt`==LOCK_STABLE_CYCLES-1 → RUN, and `retries` cleared.
  - Else `phase_cnt`++.
  - Timeout in STABLE has priority over the RUN transition.
- Timeout: `retries`++. If the new value equals MAX_RETRIES → FAIL, else → PLL_RESET with `phase_cnt` cleared.
- RUN: `ready`=1. When `lock_sync`=0 → PLL_RESET, and `lock_lost_count`++ saturating. `retries` is not touched.
- FAIL: `pll_resetb`=0, `fail`=1. Stays in FAIL until `restart` or `reset`.
- `restart`=1, in any state: → PLL_RESET with `phase_cnt` and `retries` cleared.
  - `restart` has priority over all transitions.
  - If `restart` and lock loss in RUN coincide, `lock_lost_count` is not incremented.
- Reset values:
  - state = PLL_RESET, counters 0, both synchroniser flops 0.
  - `pll_resetb`=0, `ready`=0, `fail`=0, `retries`=0, `lock_lost_count`=0.
  - `lock_lost_count` is cleared only by `reset`.

## Timing
- All outputs are registered from state. No combinational path from input to output.
- PLL hold: after the first edge with `reset`=0, `pll_resetb` stays 0 for exactly PLL_RESET_CYCLES edges, then goes 1.
- Lock-in latency: let `locked_in` be high at edge k and stay high, with the FSM in WAIT_LOCK.
  - STABLE is entered at edge k+2.
  - `ready` goes 1 at edge k+LOCK_STABLE_CYCLES+2.
- Lock-loss latency: let `locked_in` be low at edge k while in RUN.
  - `ready`=0 and `pll_resetb`=0 from edge k+2.
- Timeout: the transition fires on the LOCK_TIMEOUT_CYCLES-th edge after WAIT_LOCK entry.
- `restart` latency: outputs reflect PLL_RESET one edge after `restart` is sampled.
- `reset` in mid-sequence: all state is discarded at the next edge.

## Test plan
- Parameters for all scenarios: PLL_RESET_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
- Nominal bring-up:
  - Stimulus: release reset; raise `locked_in` 10 cycles after `pll_resetb` rises.
  - Response: `pll_resetb` low for exactly 4 cycles; `ready` rises exactly 10 cycles after `locked_in`; `retries`=0.
- Flapping lock:
  - Stimulus: `locked_in` high for 5 cycles, low for 3 cycles, repeating.
  - Response: `ready` never rises; timeout at cycle 32 from WAIT_LOCK entry; `retries`=1; `pll_resetb` re-pulsed for 4 cycles.
- Exhausted retries:
  - Stimulus: `locked_in` held 0.
  - Response: two timeouts; `fail`=1 with `retries`=2 and `pll_resetb`=0 held.
  - Then pulse `restart` with lock present: `fail`=0, `retries`=0, `ready` eventually 1.
- Lock loss in RUN:
  - Stimulus: drop `locked_in` for 1 cycle, three separate times, re-locking each time.
  - Response: `ready` falls 2 edges after each drop; `lock_lost_count`=3.
  - Also force 300 losses: count holds at 255.
- Simultaneous events:
  - Stimulus: `restart` and lock loss in the same cycle.
  - Response: PLL_RESET entered; `lock_lost_count` unchanged.
  - Stimulus: `reset` asserted during STABLE.
  - Response: all outputs at their reset values on the next edge.

Source files
------------

// File: rtl/pll_supervisor_if.sv
// Control/status bundle between the PLL supervisor and its surroundings.
// The slave side is the supervisor; the master side drives restart and lock.
interface pll_supervisor_if;
  logic       restart;
  logic       locked_in;
  logic       pll_resetb;
  logic       ready;
  logic       fail;
  logic [3:0] retries;
  logic [7:0] lock_lost_count;

  modport master (
    output restart, locked_in,
    input  pll_resetb, ready, fail, retries, lock_lost_count
  );

  modport slave (
    input  restart, locked_in,
    output pll_resetb, ready, fail, retries, lock_lost_count
  );
endinterface

// File: rtl/pll_supervisor.sv
// Bring-up sequencer for an iCE40 PLL: pulses RESETB, waits for a stable
// synchronised LOCK, retries a bounded number of times, then latches fail.
module pll_supervisor #(
  parameter int PLL_RESET_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 4096,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 3
) (
  input  logic          clock,
  input  logic          reset,
  pll_supervisor_if.slave bus
);

  localparam int SYNC_STAGES = 2;
  localparam int MAX_RS  = (PLL_RESET_CYCLES > LOCK_STABLE_CYCLES) ?
                           PLL_RESET_CYCLES : LOCK_STABLE_CYCLES;
  localparam int CNT_MAX = (MAX_RS > LOCK_TIMEOUT_CYCLES) ? MAX_RS : LOCK_TIMEOUT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] RESET_LAST   = CW'(PLL_RESET_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          phase_reg, phase_next;
  logic [CW-1:0]          timeout_reg, timeout_next;
  logic [3:0]             retries_reg, retries_next;
  logic [7:0]             lost_reg, lost_next;
  logic                   pll_resetb_reg, ready_reg, fail_reg;
  logic [SYNC_STAGES-1:0] sync_reg, sync_next;
  logic                   lock_sync;
  logic                   timeout_hit;
  logic [3:0]             retry_inc;

  // LOCK is asynchronous to the reference clock; only the last stage is used.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        assign sync_next[gi] = bus.locked_in;
      end else begin : g_chain
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  assign lock_sync   = sync_reg[SYNC_STAGES-1];
  assign timeout_hit = (timeout_reg >= TIMEOUT_LAST);
  assign retry_inc   = retries_reg + 4'd1;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg       <= '0;
      state_reg      <= S_PLL_RESET;
      phase_reg      <= '0;
      timeout_reg    <= '0;
      retries_reg    <= '0;
      lost_reg       <= '0;
      pll_resetb_reg <= 1'b0;
      ready_reg      <= 1'b0;
      fail_reg       <= 1'b0;
    end else begin
      sync_reg       <= sync_next;
      state_reg      <= state_next;
      phase_reg      <= phase_next;
      timeout_reg    <= timeout_next;
      retries_reg    <= retries_next;
      lost_reg       <= lost_next;
      // Outputs follow the state being entered, so they change on the same edge.
      pll_resetb_reg <= (state_next == S_WAIT_LOCK) || (state_next == S_STABLE) ||
                        (state_next == S_RUN);
      ready_reg      <= (state_next == S_RUN);
      fail_reg       <= (state_next == S_FAIL);
    end
  end

  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_reg;
    timeout_next = timeout_reg;
    retries_next = retries_reg;
    lost_next    = lost_reg;

    case (state_reg)
      S_PLL_RESET: begin
        if (phase_reg == RESET_LAST) begin
          state_next   = S_WAIT_LOCK;
          timeout_next = '0;
        end else begin
          phase_next = phase_reg + 1'b1;
        end
      end

      S_WAIT_LOCK, S_STABLE: begin
        timeout_next = timeout_reg + 1'b1;
        // The attempt budget is absolute from WAIT_LOCK entry, whatever the lock does.
        if (timeout_hit) begin
          retries_next = retry_inc;
          phase_next   = '0;
          state_next   = (retry_inc == RETRY_LIMIT) ? S_FAIL : S_PLL_RESET;
        end else if (state_reg == S_WAIT_LOCK) begin
          if (lock_sync) begin
            state_next = S_STABLE;
            phase_next = '0;
          end
        end else if (!lock_sync) begin
          state_next = S_WAIT_LOCK;
        end else if (phase_reg == STABLE_LAST) begin
          state_next   = S_RUN;
          retries_next = '0;
        end else begin
          phase_next = phase_reg + 1'b1;
        end
      end

      S_RUN: begin
        if (!lock_sync) begin
          state_next = S_PLL_RESET;
          phase_next = '0;
          if (lost_reg != 8'hFF) begin
            lost_next = lost_reg + 8'd1;
          end
        end
      end

      S_FAIL: begin
        state_next = S_FAIL;
      end

      default: begin
        state_next = S_PLL_RESET;
        phase_next = '0;
      end
    endcase

    // Restart overrides everything, including a coincident lock-loss count.
    if (bus.restart) begin
      state_next   = S_PLL_RESET;
      phase_next   = '0;
      retries_next = '0;
      lost_next    = lost_reg;
    end
  end

  assign bus.pll_resetb      = pll_resetb_reg;
  assign bus.ready           = ready_reg;
  assign bus.fail            = fail_reg;
  assign bus.retries         = retries_reg;
  assign bus.lock_lost_count = lost_reg;

endmodule

// File: tb/tb_pll_supervisor.sv
// Directed bench for pll_supervisor with small timing parameters
// (reset hold 4, stability 8, timeout 32, retries 2).
module tb_pll_supervisor;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pll_supervisor_if bus();

  pll_supervisor #(
    .PLL_RESET_CYCLES   (4),
    .LOCK_STABLE_CYCLES (8),
    .LOCK_TIMEOUT_CYCLES(32),
    .MAX_RETRIES        (2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.restart = 1'b0;
    bus.locked_in = 1'b0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  // Steps edges until the selected output reaches level; n = edges taken.
  task automatic wait_sig(input int sel, input logic level, input int budget,
                          output int n, output bit hit);
    logic v;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      step();
      n++;
      case (sel)
        0:       v = bus.ready;
        1:       v = bus.pll_resetb;
        default: v = bus.fail;
      endcase
      if (v === level) hit = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.restart = 1'b0;
    bus.locked_in = 1'b1;
    repeat (3) step();
    checks++; if (bus.pll_resetb !== 1'b0) begin errors++; $display("FAIL reset_pll_resetb got %b want 0", bus.pll_resetb); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.ready); end
    checks++; if (bus.fail !== 1'b0) begin errors++; $display("FAIL reset_fail got %b want 0", bus.fail); end
    checks++; if (bus.retries !== 4'd0) begin errors++; $display("FAIL reset_retries got %0d want 0", bus.retries); end
    checks++; if (bus.lock_lost_count !== 8'd0) begin errors++; $display("FAIL reset_lost got %0d want 0", bus.lock_lost_count); end
    $display("test_reset: outputs pll_resetb=%b ready=%b fail=%b", bus.pll_resetb, bus.ready, bus.fail);
  endtask

  task automatic test_bringup();
    int n; bit hit;
    bus.locked_in = 1'b0;
    reset = 1'b0;
    wait_sig(1, 1'b1, 20, n, hit);
    checks++; if (!hit || n != 4) begin errors++; $display("FAIL bringup_hold got %0d edges (hit=%b) want 4", n, hit); end
    repeat (9) step();
    bus.locked_in = 1'b1;
    step();
    wait_sig(0, 1'b1, 40, n, hit);
    checks++; if (!hit || n != 10) begin errors++; $display("FAIL bringup_ready got %0d edges (hit=%b) want 10", n, hit); end
    checks++; if (bus.retries !== 4'd0) begin errors++; $display("FAIL bringup_retries got %0d want 0", bus.retries); end
    checks++; if (bus.pll_resetb !== 1'b1 || bus.fail !== 1'b0) begin errors++; $display("FAIL bringup_run got resetb=%b fail=%b want 1/0", bus.pll_resetb, bus.fail); end
    $display("test_bringup: ready after %0d edges of lock", n);
  endtask

  task automatic test_flapping();
    int n; int m; bit hit; bit saw_ready;
    apply_reset();
    wait_sig(1, 1'b1, 20, m, hit);
    checks++; if (!hit) begin errors++; $display("FAIL flap_start got no resetb rise want rise"); end
    n = 0;
    saw_ready = 1'b0;
    while (bus.pll_resetb === 1'b1 && n < 100) begin
      bus.locked_in = ((n % 8) < 5);
      step();
      n++;
      if (bus.ready === 1'b1) saw_ready = 1'b1;
    end
    checks++; if (n != 32) begin errors++; $display("FAIL flap_timeout got %0d edges want 32", n); end
    checks++; if (saw_ready !== 1'b0) begin errors++; $display("FAIL flap_ready got ready=1 want never"); end
    checks++; if (bus.retries !== 4'd1 || bus.fail !== 1'b0) begin errors++; $display("FAIL flap_retries got %0d fail=%b want 1/0", bus.retries, bus.fail); end
    bus.locked_in = 1'b0;
    wait_sig(1, 1'b1, 20, m, hit);
    checks++; if (!hit || m != 4) begin errors++; $display("FAIL flap_repulse got %0d edges want 4", m); end
    $display("test_flapping: timeout after %0d edges, retries=%0d", n, bus.retries);
  endtask

  task automatic test_exhausted();
    int n; bit hit;
    apply_reset();
    wait_sig(2, 1'b1, 200, n, hit);
    checks++; if (!hit || n != 72) begin errors++; $display("FAIL exh_fail_time got %0d edges (hit=%b) want 72", n, hit); end
    checks++; if (bus.retries !== 4'd2 || bus.pll_resetb !== 1'b0 || bus.ready !== 1'b0) begin
      errors++; $display("FAIL exh_state got retries=%0d resetb=%b ready=%b want 2/0/0", bus.retries, bus.pll_resetb, bus.ready); end
    repeat (10) step();
    checks++; if (bus.fail !== 1'b1 || bus.pll_resetb !== 1'b0) begin errors++; $display("FAIL exh_hold got fail=%b resetb=%b want 1/0", bus.fail, bus.pll_resetb); end
    bus.locked_in = 1'b1;
    repeat (2) step();
    bus.restart = 1'b1;
    step();
    bus.restart = 1'b0;
    checks++; if (bus.fail !== 1'b0 || bus.retries !== 4'd0 || bus.pll_resetb !== 1'b0) begin
      errors++; $display("FAIL exh_restart got fail=%b retries=%0d resetb=%b want 0/0/0", bus.fail, bus.retries, bus.pll_resetb); end
    wait_sig(0, 1'b1, 40, n, hit);
    checks++; if (!hit || n != 13) begin errors++; $display("FAIL exh_relock got %0d edges (hit=%b) want 13", n, hit); end
    $display("test_exhausted: ready %0d edges after restart", n);
  endtask

  task automatic test_lock_loss();
    int n; bit hit; bit relock_ok; logic [7:0] at254; logic [7:0] at255;
    apply_reset();
    bus.locked_in = 1'b1;
    wait_sig(0, 1'b1, 50, n, hit);
    checks++; if (!hit) begin errors++; $display("FAIL loss_initial got no ready want ready"); end
    relock_ok = 1'b1;
    at254 = 8'd0;
    at255 = 8'd0;
    for (int i = 0; i < 300; i++) begin
      bus.locked_in = 1'b0;
      step();
      bus.locked_in = 1'b1;
      wait_sig(0, 1'b0, 10, n, hit);
      if (i < 3) begin
        checks++; if (!hit || n != 2) begin errors++; $display("FAIL loss_latency%0d got %0d edges want 2", i, n); end
        checks++; if (bus.pll_resetb !== 1'b0) begin errors++; $display("FAIL loss_resetb%0d got %b want 0", i, bus.pll_resetb); end
        checks++; if (bus.lock_lost_count !== 8'(i + 1)) begin errors++; $display("FAIL loss_count%0d got %0d want %0d", i, bus.lock_lost_count, i + 1); end
        $display("test_lock_loss: drop %0d ready fell after %0d edges, count=%0d", i, n, bus.lock_lost_count);
      end
      if (i == 253) at254 = bus.lock_lost_count;
      if (i == 254) at255 = bus.lock_lost_count;
      wait_sig(0, 1'b1, 50, n, hit);
      if (!hit) relock_ok = 1'b0;
    end
    checks++; if (!relock_ok) begin errors++; $display("FAIL loss_relock got missing ready want relock every time"); end
    checks++; if (at254 !== 8'd254) begin errors++; $display("FAIL loss_count254 got %0d want 254", at254); end
    checks++; if (at255 !== 8'd255) begin errors++; $display("FAIL loss_count255 got %0d want 255", at255); end
    checks++; if (bus.lock_lost_count !== 8'd255) begin errors++; $display("FAIL loss_saturate got %0d want 255", bus.lock_lost_count); end
    $display("test_lock_loss: 300 drops, count=%0d", bus.lock_lost_count);
  endtask

  task automatic test_simultaneous();
    int n; bit hit;
    apply_reset();
    bus.locked_in = 1'b1;
    wait_sig(0, 1'b1, 50, n, hit);
    bus.locked_in = 1'b0;
    step();
    bus.locked_in = 1'b1;
    wait_sig(0, 1'b0, 10, n, hit);
    wait_sig(0, 1'b1, 50, n, hit);
    checks++; if (!hit || bus.lock_lost_count !== 8'd1) begin errors++; $display("FAIL sim_setup got count=%0d hit=%b want 1/1", bus.lock_lost_count, hit); end
    bus.locked_in = 1'b0;
    step();
    step();
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL sim_pre got ready=%b want 1", bus.ready); end
    bus.restart = 1'b1;
    bus.locked_in = 1'b1;
    step();
    bus.restart = 1'b0;
    checks++; if (bus.ready !== 1'b0 || bus.pll_resetb !== 1'b0) begin errors++; $display("FAIL sim_state got ready=%b resetb=%b want 0/0", bus.ready, bus.pll_resetb); end
    checks++; if (bus.lock_lost_count !== 8'd1) begin errors++; $display("FAIL sim_count got %0d want 1", bus.lock_lost_count); end
    wait_sig(1, 1'b1, 20, n, hit);
    checks++; if (!hit || n != 4) begin errors++; $display("FAIL sim_hold got %0d edges want 4", n); end
    $display("test_simultaneous: restart+loss, count=%0d hold=%0d", bus.lock_lost_count, n);
    step();
    step();
    checks++; if (bus.pll_resetb !== 1'b1 || bus.ready !== 1'b0) begin errors++; $display("FAIL stable_pre got resetb=%b ready=%b want 1/0", bus.pll_resetb, bus.ready); end
    reset = 1'b1;
    step();
    checks++; if (bus.pll_resetb !== 1'b0 || bus.ready !== 1'b0 || bus.fail !== 1'b0 ||
                  bus.retries !== 4'd0 || bus.lock_lost_count !== 8'd0) begin
      errors++; $display("FAIL stable_reset got resetb=%b ready=%b fail=%b retries=%0d count=%0d want all 0",
                         bus.pll_resetb, bus.ready, bus.fail, bus.retries, bus.lock_lost_count); end
    reset = 1'b0;
    $display("test_simultaneous: reset during STABLE, count=%0d", bus.lock_lost_count);
  endtask

  initial begin
    bus.restart = 1'b0;
    bus.locked_in = 1'b0;
    test_reset();
    test_bringup();
    test_flapping();
    test_exhausted();
    test_lock_loss();
    test_simultaneous();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
